// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one combinational ALU between two requesters: port 0 is EX-stage
//   issue, port 1 is address/branch-target calculation. Round-robin between
//   eligible ports, one grant per cycle. The ALU result is captured into a
//   per-port registered response slot one cycle after the grant.
//
//   Optional feature: define ALU_ARB_STATS_EN to add stat0_grants and
//   stat1_grants, saturating 16-bit per-port grant counters.
module alu_share_arbiter #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   // port 0 request
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_src_a,
   input  logic [DATA_W-1:0] req0_src_b,
   input  logic [CTRL_W-1:0] req0_ctrl,
   input  logic [DATA_W-1:0] req0_pc,
   input  logic              req0_imm,
   input  logic              req0_srca_sel,
   // port 1 request
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_src_a,
   input  logic [DATA_W-1:0] req1_src_b,
   input  logic [CTRL_W-1:0] req1_ctrl,
   input  logic [DATA_W-1:0] req1_pc,
   input  logic              req1_imm,
   input  logic              req1_srca_sel,
   // responses
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic [DATA_W-1:0] rsp0_data,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [DATA_W-1:0] rsp1_data,
   // shared ALU
   output logic [DATA_W-1:0] alu_src_a,
   output logic [DATA_W-1:0] alu_src_b,
   output logic [DATA_W-1:0] alu_pc,
   output logic [CTRL_W-1:0] alu_ctrl,
   output logic              alu_imm,
   output logic              alu_srca_sel,
   input  logic [DATA_W-1:0] alu_result
`ifdef ALU_ARB_STATS_EN
   ,
   output logic [15:0]       stat0_grants,
   output logic [15:0]       stat1_grants
`endif
);

   // All-ones control code tells the ALU to idle and return zero.
   localparam logic [CTRL_W-1:0] CTRL_IDLE = '1;

   logic elig0_p0;
   logic elig1_p0;
   logic grant0_p0;
   logic grant1_p0;
   // 0 = port 0 was granted last, 1 = port 1 was granted last
   logic last_grant;

   // Eligibility and round-robin grant; nothing is granted while in reset.
   always_comb begin
      elig0_p0  = req0_valid && (!rsp0_valid || rsp0_ready);
      elig1_p0  = req1_valid && (!rsp1_valid || rsp1_ready);
      grant0_p0 = 1'b0;
      grant1_p0 = 1'b0;
      if (!rst) begin
         if (elig0_p0 && elig1_p0) begin
            grant0_p0 = last_grant;
            grant1_p0 = !last_grant;
         end else begin
            grant0_p0 = elig0_p0;
            grant1_p0 = elig1_p0;
         end
      end
      req0_ready = grant0_p0;
      req1_ready = grant1_p0;
   end

   // Steer the granted port's operands to the ALU; idle code when no grant.
   always_comb begin
      alu_src_a    = '0;
      alu_src_b    = '0;
      alu_pc       = '0;
      alu_ctrl     = CTRL_IDLE;
      alu_imm      = 1'b0;
      alu_srca_sel = 1'b0;
      if (grant0_p0) begin
         alu_src_a    = req0_src_a;
         alu_src_b    = req0_src_b;
         alu_pc       = req0_pc;
         alu_ctrl     = req0_ctrl;
         alu_imm      = req0_imm;
         alu_srca_sel = req0_srca_sel;
      end else if (grant1_p0) begin
         alu_src_a    = req1_src_a;
         alu_src_b    = req1_src_b;
         alu_pc       = req1_pc;
         alu_ctrl     = req1_ctrl;
         alu_imm      = req1_imm;
         alu_srca_sel = req1_srca_sel;
      end
   end

   // ---- stage boundary: grant (p0) -> registered response slot (p1) ----
   // Response slots and round-robin pointer. A grant overwrites the slot
   // (covers same-cycle drain + refill with no bubble); a drain without a
   // new grant only clears valid so the data stays at its last value.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp0_valid <= 1'b0;
         rsp0_data  <= '0;
         rsp1_valid <= 1'b0;
         rsp1_data  <= '0;
         last_grant <= 1'b1;
      end else begin
         if (grant0_p0) begin
            rsp0_valid <= 1'b1;
            rsp0_data  <= alu_result;
         end else if (rsp0_ready) begin
            rsp0_valid <= 1'b0;
         end

         if (grant1_p0) begin
            rsp1_valid <= 1'b1;
            rsp1_data  <= alu_result;
         end else if (rsp1_ready) begin
            rsp1_valid <= 1'b0;
         end

         if (grant0_p0) begin
            last_grant <= 1'b0;
         end else if (grant1_p0) begin
            last_grant <= 1'b1;
         end
      end
   end

`ifdef ALU_ARB_STATS_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Per-port grant counters, saturating at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat0_grants <= '0;
         stat1_grants <= '0;
      end else begin
         if (grant0_p0) begin
            stat0_grants <= sat_inc(stat0_grants);
         end
         if (grant1_p0) begin
            stat1_grants <= sat_inc(stat1_grants);
         end
      end
   end
`endif

endmodule
